// File: rtl/fx_ctrl_pkg.sv
// fx_ctrl_pkg: shared constants for the effect control bank.
// Key roles, effect channel indices and the default channel links.
package fx_ctrl_pkg;

    typedef enum logic [1:0] {
        K_INC  = 2'd0,
        K_DEC  = 2'd1,
        K_NEXT = 2'd2,
        K_DEF  = 2'd3
    } key_e;

    typedef enum logic [3:0] {
        FX_BRIGHT  = 4'd0,
        FX_BLUR    = 4'd1,
        FX_GRAY    = 4'd2,
        FX_CURSOR  = 4'd3,
        FX_CLR     = 4'd4,
        FX_GREEN   = 4'd5,
        FX_CARTOON = 4'd6,
        FX_EDGE    = 4'd7
    } fx_e;

    localparam int FX_NUM = 8;

    // Cartoon shading looks wrong without edges, so it drags edge on.
    localparam logic [FX_NUM*FX_NUM-1:0] FX_LINK_DEF =
        64'd1 << (int'(FX_CARTOON) * FX_NUM + int'(FX_EDGE));

endpackage

// File: rtl/fx_control_bank_if.sv
// fx_control_bank_if: board inputs and effect outputs of the bank.
// master drives switches/keys/frame pulse, slave is the control bank.
interface fx_control_bank_if #(
    parameter int NUM_FX = 8,
    parameter int LVL_W  = 4
);
    logic [9:0]              SW;
    logic [3:0]              KEY;
    logic                    frame_start;
    logic [NUM_FX-1:0]       en;
    logic [NUM_FX*LVL_W-1:0] lvl;
    logic [3:0]              edit_sel;
    logic                    lvl_chg;

    modport master (
        output SW, KEY, frame_start,
        input  en, lvl, edit_sel, lvl_chg
    );

    modport slave (
        input  SW, KEY, frame_start,
        output en, lvl, edit_sel, lvl_chg
    );
endinterface

// File: rtl/fx_control_bank_key.sv
// key_debounce_repeat: sync, debounce and press/auto-repeat pulse
// for one active-low push-key.
module key_debounce_repeat #(
    parameter logic [15:0] DB_CYCLES = 16'd50000,
    parameter logic [23:0] REP_DLY   = 24'd10000000,
    parameter logic [23:0] REP_PER   = 24'd2500000,
    parameter bit          REP_EN    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse
);
    logic        s1, s2;
    logic        db, db_q;
    logic        lock, live, phase;
    logic [1:0]  vld;
    logic [15:0] dcnt;
    logic [23:0] rcnt;
    logic        rise, fire;

    // lock hides a key already held when reset was released.
    assign rise = db & ~db_q & ~lock;
    assign fire = REP_EN & live & db &
                  (rcnt == (phase ? REP_PER : REP_DLY));

    // Synchronise, debounce, and arm only after a real release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            vld  <= '0;
            db   <= 1'b0;
            db_q <= 1'b0;
            dcnt <= '0;
            lock <= 1'b1;
        end else begin
            s1   <= ~key_n;
            s2   <= s1;
            vld  <= {vld[0], 1'b1};
            db_q <= db;
            if (s2 != db) begin
                if (dcnt == DB_CYCLES - 16'd1) begin
                    db   <= s2;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + 16'd1;
                end
            end else begin
                dcnt <= '0;
            end
            if (vld[1] && !s2 && !db)
                lock <= 1'b0;
        end
    end

    // Repeat timer: first gap REP_DLY, then REP_PER, idle saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt  <= '0;
            phase <= 1'b0;
            live  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= rise | fire;
            if (rise) begin
                rcnt  <= 24'd1;
                phase <= 1'b0;
                live  <= 1'b1;
            end else if (fire) begin
                rcnt  <= 24'd1;
                phase <= 1'b1;
            end else if (rcnt != '1) begin
                rcnt <= rcnt + 24'd1;
            end
            if (!db)
                live <= 1'b0;
        end
    end
endmodule

// File: rtl/fx_control_bank.sv
// fx_control_bank: switches and keys to per-effect enables and
// levels, edited in a shadow copy and applied at frame start.
module fx_control_bank
    import fx_ctrl_pkg::*;
#(
    parameter int          NUM_FX     = 8,
    parameter int          LVL_W      = 4,
    parameter int          LVL_MAX    = 15,
    parameter int          LVL_DEF    = 8,
    parameter logic [15:0] DB_CYCLES  = 16'd50000,
    parameter logic [23:0] REP_DLY    = 24'd10000000,
    parameter logic [23:0] REP_PER    = 24'd2500000,
    parameter bit          FRAME_SYNC = 1'b1,
    parameter logic [NUM_FX*NUM_FX-1:0] LINK_MASK = '0
) (
    input logic clk,
    input logic rst,
    fx_control_bank_if.slave bus
);
    localparam logic [LVL_W-1:0] L_MAX    = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0] L_DEF    = LVL_W'(LVL_DEF);
    localparam logic [3:0]       SEL_LAST = 4'(NUM_FX - 1);

    logic [3:0]              kp;
    logic [3:0]              sel;
    logic                    chg;
    logic [LVL_W-1:0]        sh [NUM_FX];
    logic [LVL_W-1:0]        cur, nxt;
    logic [NUM_FX-1:0]       raw, sh_en, en_q;
    logic [NUM_FX*LVL_W-1:0] sh_lvl, lvl_q;
    logic                    unused_sw;

    assign unused_sw = ^bus.SW;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce_repeat #(
            .DB_CYCLES(DB_CYCLES),
            .REP_DLY  (REP_DLY),
            .REP_PER  (REP_PER),
            .REP_EN   (k == int'(K_INC) || k == int'(K_DEC))
        ) u_key (
            .clk  (clk),
            .rst  (rst),
            .key_n(bus.KEY[k]),
            .pulse(kp[k])
        );
    end

    // Next shadow level of the edited channel; restore beats inc/dec.
    always_comb begin
        cur = sh[0];
        for (int i = 1; i < NUM_FX; i++)
            if (sel == 4'(i)) cur = sh[i];
        nxt = cur;
        if (kp[K_DEF])
            nxt = L_DEF;
        else if (kp[K_INC] && !kp[K_DEC])
            nxt = (cur < L_MAX) ? cur + LVL_W'(1) : L_MAX;
        else if (kp[K_DEC] && !kp[K_INC])
            nxt = (cur != '0) ? cur - LVL_W'(1) : cur;
    end

    // Shadow levels and edit pointer; pointer moves after the edit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel <= '0;
            chg <= 1'b0;
            for (int i = 0; i < NUM_FX; i++)
                sh[i] <= L_DEF;
        end else begin
            chg <= (nxt != cur);
            for (int i = 0; i < NUM_FX; i++)
                if (sel == 4'(i)) sh[i] <= nxt;
            if (kp[K_NEXT])
                sel <= (sel == SEL_LAST) ? 4'd0 : sel + 4'd1;
        end
    end

    // Shadow enables with one level of linking, plus packed levels.
    always_comb begin
        raw    = bus.SW[NUM_FX:1];
        sh_en  = raw;
        sh_lvl = '0;
        for (int i = 0; i < NUM_FX; i++)
            for (int j = 0; j < NUM_FX; j++)
                if (raw[i] && LINK_MASK[i*NUM_FX+j]) sh_en[j] = 1'b1;
        for (int i = 0; i < NUM_FX; i++)
            sh_lvl[i*LVL_W +: LVL_W] = sh[i];
    end

    // Apply stage: load at frame start so a frame never sees a change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q  <= '0;
            lvl_q <= {NUM_FX{L_DEF}};
        end else if (!FRAME_SYNC || bus.frame_start) begin
            en_q  <= sh_en;
            lvl_q <= sh_lvl;
        end
    end

    assign bus.en       = en_q;
    assign bus.lvl      = lvl_q;
    assign bus.edit_sel = sel;
    assign bus.lvl_chg  = chg;
endmodule

// File: tb/tb_fx_control_bank.sv
// tb_fx_control_bank: directed tables, corner sequences and random
// key/switch traffic checked against a key-event level model.
module tb_fx_control_bank;
    import fx_ctrl_pkg::*;

    localparam int NFX = 8;
    localparam int LW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fx_control_bank_if #(.NUM_FX(NFX), .LVL_W(LW)) bus ();

    fx_control_bank #(
        .NUM_FX    (NFX),
        .LVL_W     (LW),
        .LVL_MAX   (15),
        .LVL_DEF   (8),
        .DB_CYCLES (16'd4),
        .REP_DLY   (24'd20),
        .REP_PER   (24'd5),
        .FRAME_SYNC(1'b1),
        .LINK_MASK (FX_LINK_DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] m;
        int         sel;
        int         ch;
        int         lvl;
        int         chg;
    } vec_t;

    typedef struct {
        logic [9:0] sw;
        logic [7:0] en;
    } swv_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   chg_cnt = 0;
    int   chg_t[$];
    int   m_lvl[NFX];
    int   m_sel;
    vec_t tv[$];
    swv_t sv[$];

    always @(posedge clk) begin
        cyc++;
        if (bus.lvl_chg === 1'b1) begin
            chg_cnt++;
            chg_t.push_back(cyc);
        end
    end

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NFX; i++) m_lvl[i] = 8;
        m_sel = 0;
    endfunction

    function automatic int m_press(logic [3:0] m);
        int old;
        old = m_lvl[m_sel];
        if (m[3])
            m_lvl[m_sel] = 8;
        else if (m[0] && !m[1])
            m_lvl[m_sel] = (old < 15) ? old + 1 : 15;
        else if (m[1] && !m[0])
            m_lvl[m_sel] = (old > 0) ? old - 1 : 0;
        if (m[2]) m_sel = (m_sel + 1) % NFX;
        return (m_lvl[(m[2] ? m_sel + NFX - 1 : m_sel) % NFX] != old)
               ? 1 : 0;
    endfunction

    function automatic logic [31:0] m_pack();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < NFX; i++) r[i*LW +: LW] = 4'(m_lvl[i]);
        return r;
    endfunction

    function automatic logic [7:0] m_en(logic [9:0] sw);
        logic [7:0] r;
        r = sw[8:1];
        if (sw[7]) r[7] = 1'b1;
        return r;
    endfunction

    function automatic void add(logic [3:0] m, int sel, int ch,
                                int lvl, int chg);
        vec_t v;
        v.m = m; v.sel = sel; v.ch = ch; v.lvl = lvl; v.chg = chg;
        tv.push_back(v);
    endfunction

    function automatic void add_sw(logic [9:0] sw, logic [7:0] en);
        swv_t v;
        v.sw = sw; v.en = en;
        sv.push_back(v);
    endfunction

    task automatic cyc_n(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(logic [3:0] m, int hold);
        bus.KEY = ~m;
        cyc_n(hold);
        bus.KEY = 4'hF;
        cyc_n(10);
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        cyc_n(1);
        bus.frame_start = 1'b0;
        cyc_n(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         base;
        int         d;
        int         gaps[5];
        logic [3:0] m;

        for (int i = 0; i < 8; i++)
            add(4'b0100, (i + 1) % 8, i, (i == 0) ? 15 : 8, 0);
        for (int i = 0; i < 3; i++)
            add(4'b0100, i + 1, i, (i == 0) ? 15 : 8, 0);
        add(4'b0110, 4, 3, 7, 1);
        for (int i = 0; i < 6; i++)
            add(4'b0100, (i + 5) % 8, (i + 4) % 8,
                ((i + 4) % 8 == 0) ? 15 : 8, 0);
        for (int i = 0; i < 4; i++)
            add(4'b0001, 2, 2, 9 + i, 1);
        add(4'b1001, 2, 2, 8, 1);
        for (int i = 0; i < 10; i++)
            add(4'b0010, 2, 2, (i < 8) ? 7 - i : 0, (i < 8) ? 1 : 0);

        add_sw(10'h100, 8'h80);
        add_sw(10'h07E, 8'h3F);
        add_sw(10'h0FE, 8'hFF);
        add_sw(10'h001, 8'h00);
        add_sw(10'h200, 8'h00);
        add_sw(10'h040, 8'h20);
        add_sw(10'h3FF, 8'hFF);

        gaps = '{20, 5, 5, 5, 5};

        bus.SW = '0;
        bus.KEY = 4'hF;
        bus.frame_start = 1'b0;
        m_reset();
        cyc_n(3);
        chk("rst_en", bus.en, 0);
        chk("rst_lvl", bus.lvl, {8{4'h8}});
        chk("rst_sel", bus.edit_sel, 0);
        chk("rst_chg", bus.lvl_chg, 0);
        rst = 1'b1;
        cyc_n(5);

        // bounce then a clean hold gives exactly one press
        base = chg_cnt;
        bus.KEY[0] = 1'b1; cyc_n(1);
        bus.KEY[0] = 1'b0; cyc_n(1);
        bus.KEY[0] = 1'b1; cyc_n(1);
        bus.KEY[0] = 1'b0; cyc_n(10);
        bus.KEY[0] = 1'b1; cyc_n(10);
        d = m_press(4'b0001);
        chk("bounce_pulses", chg_cnt - base, d);
        chk("bounce_sel", bus.edit_sel, 0);
        chk("lvl_before_frame", bus.lvl, {8{4'h8}});
        frame();
        chk("lvl_after_frame", bus.lvl, {{7{4'h8}}, 4'h9});

        // hold: press, repeat after 20, then every 5, until saturation
        chg_t.delete();
        bus.KEY[0] = 1'b0;
        cyc_n(60);
        bus.KEY[0] = 1'b1;
        cyc_n(15);
        for (int i = 0; i < 6; i++) d = m_press(4'b0001);
        chk("rep_count", chg_t.size(), 6);
        for (int i = 1; i < 6; i++)
            chk($sformatf("rep_gap%0d", i),
                (i < chg_t.size()) ? chg_t[i] - chg_t[i-1] : -1,
                gaps[i-1]);
        frame();
        chk("rep_sat_lvl", bus.lvl, m_pack());

        // directed key table
        foreach (tv[r]) begin
            base = chg_cnt;
            press(tv[r].m, 8);
            d = m_press(tv[r].m);
            chk($sformatf("tab_sel[%0d]", r), bus.edit_sel, tv[r].sel);
            chk($sformatf("tab_chg[%0d]", r), chg_cnt - base, tv[r].chg);
            frame();
            chk($sformatf("tab_lvl[%0d]", r),
                bus.lvl[tv[r].ch*LW +: LW], tv[r].lvl);
        end
        chk("tab_model", bus.lvl, m_pack());

        // enables follow switches only at frame start, with links
        bus.SW = 10'h080;
        cyc_n(3);
        chk("en_pre_frame", bus.en, 8'h00);
        frame();
        chk("en_cartoon_edge", bus.en, 8'hC0);
        bus.SW = 10'h002;
        cyc_n(5);
        chk("en_mid_frame", bus.en, 8'hC0);
        frame();
        chk("en_next_frame", bus.en, 8'h01);
        foreach (sv[r]) begin
            bus.SW = sv[r].sw;
            cyc_n(2);
            frame();
            chk($sformatf("sw_tab[%0d]", r), bus.en, sv[r].en);
        end

        // reset in the middle of a hold
        bus.KEY[0] = 1'b0;
        cyc_n(30);
        rst = 1'b0;
        cyc_n(1);
        chk("midrst_en", bus.en, 0);
        chk("midrst_lvl", bus.lvl, {8{4'h8}});
        chk("midrst_sel", bus.edit_sel, 0);
        chk("midrst_chg", bus.lvl_chg, 0);
        rst = 1'b1;
        base = chg_cnt;
        cyc_n(40);
        chk("midrst_no_pulse", chg_cnt - base, 0);
        frame();
        chk("midrst_hold_lvl", bus.lvl, {8{4'h8}});
        bus.KEY[0] = 1'b1;
        cyc_n(10);
        m_reset();
        base = chg_cnt;
        press(4'b0001, 8);
        d = m_press(4'b0001);
        chk("repress_chg", chg_cnt - base, d);
        frame();
        chk("repress_lvl", bus.lvl, m_pack());

        // random key combinations and switches against the model
        for (int it = 0; it < 40; it++) begin
            m = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bus.SW = 10'($urandom);
            base = chg_cnt;
            press(m, 8);
            d = m_press(m);
            chk("rnd_sel", bus.edit_sel, m_sel);
            chk("rnd_chg", chg_cnt - base, d);
            frame();
            chk("rnd_lvl", bus.lvl, m_pack());
            chk("rnd_en", bus.en, m_en(bus.SW));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
